div_issue_queue: RTL

Age-ordered issue queue that sits between rename/dispatch and the sequential divider unit. It buffers up to DEPTH divide/remainder entries and tracks source-operand readiness through CDB wakeups. When the divider reports idle, it drives a single-cycle `start` pulse along with the oldest ready entry. It is the producer side of the divider's `start` / `DIV_RS_next` / `sent_valid` handshake.

---
 rtl/div_issue_queue_if.sv | 64 ++++++
 rtl/div_issue_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_issue_queue_if.sv
// div_issue_queue_if: shared entry type plus the bundle of dispatch, CDB and
// divider-side signals around the divide issue queue.
//
// div_iq_pkg
//   P_WIDTH : physical register tag width
//   RS_t    : divide/remainder reservation entry
//
// div_issue_queue_if #(DEPTH)
//   flush, dispatch_valid, dispatch_entry, dispatch_rs1_ready,
//   dispatch_rs2_ready, cdb_valid, cdb_paddr, div_idle  -> into the queue
//   dispatch_ready, start, DIV_RS_next, count           -> out of the queue
//   modport master : the queue's view
//   modport slave  : the surrounding pipeline's view (dispatch, CDB, divider)
//
// Handshakes:
//   dispatch : an entry moves when dispatch_valid && dispatch_ready at the
//              clock edge; dispatch_ready depends only on registered state.
//   divider  : the divider takes DIV_RS_next when start is high at the edge;
//              start is only raised while div_idle is high, and div_idle
//              drops the cycle after start, so start is a one-cycle pulse.
package div_iq_pkg;
   localparam int P_WIDTH = 6;

   typedef struct packed {
      logic               valid;
      logic [1:0]         op;        // div, divu, rem, remu
      logic [P_WIDTH-1:0] rd_paddr;
      logic               rs1_use;
      logic [P_WIDTH-1:0] rs1_paddr;
      logic               rs2_use;
      logic [P_WIDTH-1:0] rs2_paddr;
   } RS_t;
endpackage

interface div_issue_queue_if #(
   parameter int DEPTH = 4
);
   import div_iq_pkg::*;

   logic                       flush;
   logic                       dispatch_valid;
   RS_t                        dispatch_entry;
   logic                       dispatch_rs1_ready;
   logic                       dispatch_rs2_ready;
   logic                       dispatch_ready;
   logic                       cdb_valid;
   logic [P_WIDTH-1:0]         cdb_paddr;
   logic                       div_idle;
   logic                       start;
   RS_t                        DIV_RS_next;
   logic [$clog2(DEPTH+1)-1:0] count;

   modport master (
      input  flush, dispatch_valid, dispatch_entry, dispatch_rs1_ready,
             dispatch_rs2_ready, cdb_valid, cdb_paddr, div_idle,
      output dispatch_ready, start, DIV_RS_next, count
   );

   modport slave (
      output flush, dispatch_valid, dispatch_entry, dispatch_rs1_ready,
             dispatch_rs2_ready, cdb_valid, cdb_paddr, div_idle,
      input  dispatch_ready, start, DIV_RS_next, count
   );
endinterface

// File: rtl/div_issue_queue.sv
// div_issue_queue: age-ordered issue queue in front of the sequential divider.
// Holds up to DEPTH entries in a collapsing array (slot 0 = oldest), tracks
// operand readiness from CDB wakeups, and pulses start with the oldest ready
// entry whenever the divider reports idle.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : div_issue_queue_if.master (dispatch, CDB, divider handshake, count)
//
// Optional feature: define DIV_IQ_BYPASS_EN to let a fully ready dispatch
// issue in the same cycle without occupying a slot when the queue has no
// ready entry and the divider is idle.
module div_issue_queue
   import div_iq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   div_issue_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      RS_t  entry;
      logic r1_rdy;
      logic r2_rdy;
   } slot_t;

   slot_t            slot_q [DEPTH];
   slot_t            slot_d [DEPTH];
   slot_t            slot_w [DEPTH];   // slot contents with this cycle's wakeup applied
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   logic             cdb_hit;
   logic [DEPTH-1:0] rdy;
   logic             any_rdy;
   int               sel;
   logic             issue_sel;        // queue slot leaves this cycle
   logic             byp;              // dispatch goes straight to the divider
   logic             enq;
   int               enq_idx;
   logic             disp_r1;
   logic             disp_r2;
   logic             dispatch_ready_w;
   RS_t              issue_entry;

   always_comb begin
      cdb_hit          = bus.cdb_valid && (bus.cdb_paddr != '0);
      dispatch_ready_w = int'(count_q) < DEPTH;
      rdy              = '0;
      sel              = 0;

      // Readiness uses only registered bits: a wakeup this cycle makes the
      // entry issuable next cycle, never in the same one.
      for (int i = 0; i < DEPTH; i++) begin
         slot_w[i] = slot_q[i];
         if (cdb_hit && slot_q[i].entry.rs1_use &&
             slot_q[i].entry.rs1_paddr == bus.cdb_paddr)
            slot_w[i].r1_rdy = 1'b1;
         if (cdb_hit && slot_q[i].entry.rs2_use &&
             slot_q[i].entry.rs2_paddr == bus.cdb_paddr)
            slot_w[i].r2_rdy = 1'b1;
         rdy[i] = (i < int'(count_q)) &&
                  (!slot_q[i].entry.rs1_use || slot_q[i].r1_rdy) &&
                  (!slot_q[i].entry.rs2_use || slot_q[i].r2_rdy);
      end

      // Scan downward so the lowest ready index (oldest) wins.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rdy[i]) sel = i;
      end
      any_rdy   = |rdy;
      issue_sel = bus.div_idle && any_rdy && !bus.flush && !rst;

      // The entry being dispatched also sees the CDB broadcast of this cycle.
      disp_r1 = bus.dispatch_rs1_ready ||
                (cdb_hit && bus.dispatch_entry.rs1_use &&
                 bus.dispatch_entry.rs1_paddr == bus.cdb_paddr);
      disp_r2 = bus.dispatch_rs2_ready ||
                (cdb_hit && bus.dispatch_entry.rs2_use &&
                 bus.dispatch_entry.rs2_paddr == bus.cdb_paddr);

`ifdef DIV_IQ_BYPASS_EN
      // Bypass readiness deliberately ignores the same-cycle CDB match.
      byp = bus.dispatch_valid && dispatch_ready_w && !any_rdy &&
            bus.div_idle && !bus.flush && !rst &&
            (!bus.dispatch_entry.rs1_use || bus.dispatch_rs1_ready) &&
            (!bus.dispatch_entry.rs2_use || bus.dispatch_rs2_ready);
`else
      byp = 1'b0;
`endif

      issue_entry = '0;
      if (issue_sel) begin
         issue_entry       = slot_q[sel].entry;
         issue_entry.valid = 1'b1;
      end else if (byp) begin
         issue_entry       = bus.dispatch_entry;
         issue_entry.valid = 1'b1;
      end

      enq     = bus.dispatch_valid && dispatch_ready_w && !bus.flush && !byp;
      enq_idx = int'(count_q) - (issue_sel ? 1 : 0);

      // Collapse: slots at or above the issued one take their upper
      // neighbour, carrying the wakeup applied this cycle.
      for (int i = 0; i < DEPTH - 1; i++) begin
         slot_d[i] = slot_w[i];
         if (issue_sel && i >= sel) slot_d[i] = slot_w[i + 1];
      end
      slot_d[DEPTH-1] = slot_w[DEPTH-1];
      if (issue_sel) slot_d[DEPTH-1] = '0;

      if (enq) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == enq_idx) begin
               slot_d[i].entry       = bus.dispatch_entry;
               slot_d[i].entry.valid = 1'b1;
               slot_d[i].r1_rdy      = disp_r1;
               slot_d[i].r2_rdy      = disp_r2;
            end
         end
      end

      count_d = count_q;
      if (enq && !issue_sel)      count_d = count_q + CW'(1);
      else if (!enq && issue_sel) count_d = count_q - CW'(1);

      // Flush drops everything, including a same-cycle dispatch.
      if (bus.flush) begin
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      end
   end

   assign bus.start          = issue_sel || byp;
   assign bus.DIV_RS_next    = issue_entry;
   assign bus.count          = count_q;
   assign bus.dispatch_ready = dispatch_ready_w;

endmodule
